// File: rtl/lieat_ifu_ifetch_rsp_pkg.sv
// Shared IFU fetch-response constants.
package lieat_ifu_ifetch_rsp_pkg;
    localparam int unsigned    XLEN       = 32;
    localparam int unsigned    INSTR_W    = 32;
    localparam logic [31:0]    PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0]    NOP_INSTR  = 32'h0000_0013;
endpackage

// File: rtl/lieat_general_dfflr.sv
// Load-enabled flop bank with synchronous active-low reset to zero.
module lieat_general_dfflr #(
    parameter int unsigned DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          lden_i,
    input  logic [DW-1:0] dnxt_i,
    output logic [DW-1:0] qout_o
);
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            qout_o <= '0;
        end else if (lden_i) begin
            qout_o <= dnxt_i;
        end
    end
endmodule

// File: rtl/lieat_ifu_ifetch_rsp_buf.sv
// In-order circular buffer of outstanding fetches: alloc at issue, fill on
// memory response, pop at head; kill_all marks every entry for silent drain.
module lieat_ifu_ifetch_rsp_buf
    import lieat_ifu_ifetch_rsp_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               alloc_i,
    input  logic [XLEN-1:0]    alloc_pc_i,
    input  logic               fill_i,
    input  logic [INSTR_W-1:0] fill_instr_i,
    input  logic               fill_err_i,
    input  logic               pop_i,
    input  logic               kill_all_i,
    output logic [XLEN-1:0]    head_pc_o,
    output logic [INSTR_W-1:0] head_instr_o,
    output logic               head_err_o,
    output logic               head_filled_o,
    output logic               head_kill_o
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0] alloc_ptr_q, fill_ptr_q, pop_ptr_q;
    logic [DEPTH-1:0][XLEN-1:0]    pc_q;
    logic [DEPTH-1:0][INSTR_W:0]   data_q;
    logic [DEPTH-1:0]              filled_q;
    logic [DEPTH-1:0]              kill_q;

    lieat_general_dfflr #(.DW(PW)) u_alloc_ptr (
        .clk_i(clk_i), .rst_ni(rst_ni), .lden_i(alloc_i),
        .dnxt_i(alloc_ptr_q + PW'(1)), .qout_o(alloc_ptr_q));
    lieat_general_dfflr #(.DW(PW)) u_fill_ptr (
        .clk_i(clk_i), .rst_ni(rst_ni), .lden_i(fill_i),
        .dnxt_i(fill_ptr_q + PW'(1)), .qout_o(fill_ptr_q));
    lieat_general_dfflr #(.DW(PW)) u_pop_ptr (
        .clk_i(clk_i), .rst_ni(rst_ni), .lden_i(pop_i),
        .dnxt_i(pop_ptr_q + PW'(1)), .qout_o(pop_ptr_q));

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic sel_alloc, sel_fill;
        assign sel_alloc = alloc_i && (alloc_ptr_q == PW'(i));
        assign sel_fill  = fill_i  && (fill_ptr_q  == PW'(i));

        lieat_general_dfflr #(.DW(XLEN)) u_pc (
            .clk_i(clk_i), .rst_ni(rst_ni), .lden_i(sel_alloc),
            .dnxt_i(alloc_pc_i), .qout_o(pc_q[i]));
        lieat_general_dfflr #(.DW(INSTR_W + 1)) u_data (
            .clk_i(clk_i), .rst_ni(rst_ni), .lden_i(sel_fill),
            .dnxt_i({fill_instr_i, fill_err_i}), .qout_o(data_q[i]));
        lieat_general_dfflr #(.DW(1)) u_filled (
            .clk_i(clk_i), .rst_ni(rst_ni), .lden_i(sel_alloc | sel_fill),
            .dnxt_i(sel_fill), .qout_o(filled_q[i]));
        // A fresh allocation wins over kill_all so the flush-target fetch survives.
        lieat_general_dfflr #(.DW(1)) u_kill (
            .clk_i(clk_i), .rst_ni(rst_ni), .lden_i(sel_alloc | kill_all_i),
            .dnxt_i(~sel_alloc), .qout_o(kill_q[i]));
    end

    assign head_pc_o     = pc_q[pop_ptr_q];
    assign head_instr_o  = data_q[pop_ptr_q][INSTR_W:1];
    assign head_err_o    = data_q[pop_ptr_q][0];
    assign head_filled_o = filled_q[pop_ptr_q];
    assign head_kill_o   = kill_q[pop_ptr_q];
endmodule

// File: rtl/lieat_ifu_ifetch_rsp.sv
// IFU fetch response: issues requests to imem, tracks them in order, delivers
// pc/instr to decode and drops responses of fetches killed by a flush.
module lieat_ifu_ifetch_rsp
    import lieat_ifu_ifetch_rsp_pkg::*;
#(
    parameter int unsigned XLEN  = lieat_ifu_ifetch_rsp_pkg::XLEN,
    parameter int unsigned DEPTH = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_i_valid,
    output logic               req_i_ready,
    input  logic [XLEN-1:0]    req_i_pc,
    input  logic               req_i_flush,
    output logic               mem_o_valid,
    input  logic               mem_i_ready,
    output logic [XLEN-1:0]    mem_o_addr,
    input  logic               mem_i_rvalid,
    input  logic [INSTR_W-1:0] mem_i_rdata,
    input  logic               mem_i_err,
    output logic               rsp_o_valid,
    input  logic               rsp_i_ready,
    output logic [XLEN-1:0]    rsp_o_pc,
    output logic [INSTR_W-1:0] rsp_o_instr,
    output logic               rsp_o_err
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] pend_q, pend_d;
    logic          not_full, alloc, fill, pop;
    logic          head_filled, head_kill;

    assign not_full    = count_q < CW'(DEPTH);
    assign mem_o_valid = req_i_valid & not_full;
    assign mem_o_addr  = req_i_pc;
    assign req_i_ready = mem_i_ready & not_full;
    assign alloc       = req_i_valid & req_i_ready;
    // pend_q counts allocated-but-unfilled entries; stray responses are dropped.
    assign fill        = mem_i_rvalid & (pend_q != '0);

    assign rsp_o_valid = head_filled & ~head_kill & ~req_i_flush & (count_q != '0);
    assign pop = (count_q != '0) & head_filled & (head_kill | (rsp_o_valid & rsp_i_ready));

    always_comb begin
        count_d = count_q;
        pend_d  = pend_q;
        if (alloc && !pop) count_d = count_q + CW'(1);
        else if (!alloc && pop) count_d = count_q - CW'(1);
        if (alloc && !fill) pend_d = pend_q + CW'(1);
        else if (!alloc && fill) pend_d = pend_q - CW'(1);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
            pend_q  <= '0;
        end else begin
            count_q <= count_d;
            pend_q  <= pend_d;
        end
    end

    lieat_ifu_ifetch_rsp_buf #(.XLEN(XLEN), .DEPTH(DEPTH)) u_buf (
        .clk_i        (clock),
        .rst_ni       (reset),
        .alloc_i      (alloc),
        .alloc_pc_i   (req_i_pc),
        .fill_i       (fill),
        .fill_instr_i (mem_i_rdata),
        .fill_err_i   (mem_i_err),
        .pop_i        (pop),
        .kill_all_i   (req_i_flush),
        .head_pc_o    (rsp_o_pc),
        .head_instr_o (rsp_o_instr),
        .head_err_o   (rsp_o_err),
        .head_filled_o(head_filled),
        .head_kill_o  (head_kill)
    );
endmodule

// File: tb/tb_lieat_ifu_ifetch_rsp.sv
// Bench for lieat_ifu_ifetch_rsp: memory model plus in-order scoreboard.
module tb_lieat_ifu_ifetch_rsp;
    logic        clock = 1'b0;
    logic        reset;
    logic        req_i_valid, req_i_ready, req_i_flush;
    logic [31:0] req_i_pc;
    logic        mem_o_valid, mem_i_ready;
    logic [31:0] mem_o_addr;
    logic        mem_i_rvalid, mem_i_err;
    logic [31:0] mem_i_rdata;
    logic        rsp_o_valid, rsp_i_ready, rsp_o_err;
    logic [31:0] rsp_o_pc, rsp_o_instr;

    lieat_ifu_ifetch_rsp #(.XLEN(32), .DEPTH(2)) dut (
        .clock(clock), .reset(reset),
        .req_i_valid(req_i_valid), .req_i_ready(req_i_ready),
        .req_i_pc(req_i_pc), .req_i_flush(req_i_flush),
        .mem_o_valid(mem_o_valid), .mem_i_ready(mem_i_ready), .mem_o_addr(mem_o_addr),
        .mem_i_rvalid(mem_i_rvalid), .mem_i_rdata(mem_i_rdata), .mem_i_err(mem_i_err),
        .rsp_o_valid(rsp_o_valid), .rsp_i_ready(rsp_i_ready),
        .rsp_o_pc(rsp_o_pc), .rsp_o_instr(rsp_o_instr), .rsp_o_err(rsp_o_err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } exp_t;
    typedef struct packed {
        logic [31:0] data;
        logic        err;
        int unsigned due;
    } mrsp_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        logic        err;
        int unsigned lat;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic        exp_err;
        int unsigned exp_cycles;
    } vec_t;

    exp_t        exp_q[$];
    mrsp_t       mem_q[$];
    int unsigned cyc = 0;
    int unsigned last_del_cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    // Memory model: in-order responses, each no earlier than its due cycle.
    initial begin
        mrsp_t r;
        mem_i_rvalid = 1'b0;
        mem_i_rdata  = '0;
        mem_i_err    = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
                r = mem_q.pop_front();
                mem_i_rvalid = 1'b1;
                mem_i_rdata  = r.data;
                mem_i_err    = r.err;
            end else begin
                mem_i_rvalid = 1'b0;
                mem_i_rdata  = '0;
                mem_i_err    = 1'b0;
            end
        end
    end

    // Decode-side monitor: every delivered instruction must match the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset && rsp_o_valid && rsp_i_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got pc %h instr %h, required no delivery", rsp_o_pc, rsp_o_instr);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_pc", rsp_o_pc, e.pc);
                    chk("rsp_instr", rsp_o_instr, e.instr);
                    chk1("rsp_err", rsp_o_err, e.err);
                end
                last_del_cyc = cyc;
            end
        end
    end

    task automatic issue(input logic [31:0] pc, input logic [31:0] data, input logic err,
                         input int unsigned lat, input bit expect_it, input bit flush,
                         output int unsigned acc_cyc);
        bit done = 1'b0;
        acc_cyc = 0;
        req_i_valid = 1'b1;
        req_i_pc    = pc;
        req_i_flush = flush;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clock);
            if (flush && n == 0) chk1("flush_cycle_rsp_valid", rsp_o_valid, 1'b0);
            if (req_i_ready) begin
                chk1("mem_valid", mem_o_valid, 1'b1);
                chk("mem_addr", mem_o_addr, pc);
                mem_q.push_back('{data, err, cyc + lat});
                if (expect_it) exp_q.push_back('{pc, data, err});
                acc_cyc = cyc;
                done = 1'b1;
            end
            @(posedge clock);
            #1;
            req_i_flush = 1'b0;
        end
        req_i_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_accept_timeout: pc %h never accepted, required accept", pc);
        end
    endtask

    task automatic wait_drain(input int unsigned budget);
        for (int n = 0; n < budget && (exp_q.size() != 0 || mem_q.size() != 0); n++) begin
            @(posedge clock);
            #1;
        end
        @(posedge clock);
        #1;
        chk("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[5];
        int unsigned a1, a2, a3, ready_cyc;
        logic        waited;

        vecs[0] = '{32'h8000_0000, 32'h0000_0013, 1'b0, 1, 32'h8000_0000, 32'h0000_0013, 1'b0, 2};
        vecs[1] = '{32'h0000_0500, 32'hDEAD_BEEF, 1'b1, 2, 32'h0000_0500, 32'hDEAD_BEEF, 1'b1, 3};
        vecs[2] = '{32'h0000_0504, 32'h0010_0093, 1'b0, 1, 32'h0000_0504, 32'h0010_0093, 1'b0, 2};
        vecs[3] = '{32'hFFFF_FFFC, 32'hFFFF_FFFF, 1'b0, 4, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 1'b0, 5};
        vecs[4] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1, 32'h0000_0000, 32'h0000_0000, 1'b1, 2};

        reset       = 1'b0;
        req_i_valid = 1'b1;
        req_i_pc    = 32'h0000_1234;
        req_i_flush = 1'b0;
        mem_i_ready = 1'b1;
        rsp_i_ready = 1'b1;

        // Reset state and combinational command path.
        @(posedge clock);
        @(negedge clock);
        chk1("reset_rsp_valid", rsp_o_valid, 1'b0);
        chk("reset_rsp_pc", rsp_o_pc, 32'h0);
        chk("reset_rsp_instr", rsp_o_instr, 32'h0);
        chk1("reset_rsp_err", rsp_o_err, 1'b0);
        chk1("reset_mem_valid", mem_o_valid, 1'b1);
        chk("reset_mem_addr", mem_o_addr, 32'h0000_1234);
        chk1("reset_req_ready", req_i_ready, 1'b1);
        mem_i_ready = 1'b0;
        #1;
        chk1("req_ready_follows_mem", req_i_ready, 1'b0);
        mem_i_ready = 1'b1;
        req_i_valid = 1'b0;
        #1;
        chk1("mem_valid_idle", mem_o_valid, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Single fetches from the table, including error responses and latency.
        for (int unsigned i = 0; i < 5; i++) begin
            issue(vecs[i].pc, vecs[i].rdata, vecs[i].err, vecs[i].lat, 1'b0, 1'b0, a1);
            exp_q.push_back('{vecs[i].exp_pc, vecs[i].exp_instr, vecs[i].exp_err});
            wait_drain(30);
            chk("vec_latency", last_del_cyc - a1, vecs[i].exp_cycles);
        end

        // Back-to-back with DEPTH=2: third request waits for a free slot.
        issue(32'h100, 32'h1111_0100, 1'b0, 3, 1'b1, 1'b0, a1);
        issue(32'h104, 32'h1111_0104, 1'b0, 3, 1'b1, 1'b0, a2);
        issue(32'h108, 32'h1111_0108, 1'b0, 3, 1'b1, 1'b0, a3);
        chk("b2b_second_accept", a2 - a1, 1);
        chk("b2b_third_accept", a3 - a1, 5);
        wait_drain(40);

        // Flush with two outstanding: only the post-flush fetch reaches decode.
        issue(32'h200, 32'h2222_0200, 1'b0, 6, 1'b0, 1'b0, a1);
        issue(32'h204, 32'h2222_0204, 1'b0, 6, 1'b0, 1'b0, a2);
        issue(32'h400, 32'h4444_0400, 1'b0, 1, 1'b1, 1'b1, a3);
        wait_drain(40);

        // Flush over a filled, stalled head; target accepted in the flush cycle.
        rsp_i_ready = 1'b0;
        issue(32'h220, 32'h2222_0220, 1'b0, 1, 1'b0, 1'b0, a1);
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        chk1("pre_flush_head_valid", rsp_o_valid, 1'b1);
        rsp_i_ready = 1'b1;
        issue(32'h420, 32'h4444_0420, 1'b0, 2, 1'b1, 1'b1, a2);
        chk("flush_target_accept", a2 - a1, 4);
        wait_drain(40);

        // Decode stall: outputs hold, then pop on the first ready cycle.
        rsp_i_ready = 1'b0;
        issue(32'h300, 32'h0030_0313, 1'b0, 1, 1'b1, 1'b0, a1);
        waited = 1'b0;
        for (int n = 0; n < 10 && !waited; n++) begin
            @(negedge clock);
            waited = rsp_o_valid;
        end
        chk1("stall_head_valid", waited, 1'b1);
        for (int n = 0; n < 5; n++) begin
            @(negedge clock);
            chk1("stall_valid", rsp_o_valid, 1'b1);
            chk("stall_pc", rsp_o_pc, 32'h300);
            chk("stall_instr", rsp_o_instr, 32'h0030_0313);
        end
        @(posedge clock);
        #1;
        rsp_i_ready = 1'b1;
        ready_cyc = cyc;
        wait_drain(20);
        chk("stall_pop_cycle", last_del_cyc, ready_cyc);

        // Reset with two outstanding; their late responses must be ignored.
        issue(32'h600, 32'h6666_0600, 1'b0, 5, 1'b0, 1'b0, a1);
        issue(32'h604, 32'h6666_0604, 1'b0, 5, 1'b0, 1'b0, a2);
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clock);
            chk1("post_reset_rsp_valid", rsp_o_valid, 1'b0);
            chk1("post_reset_req_ready", req_i_ready, 1'b1);
        end
        chk("stray_rsp_consumed", mem_q.size(), 0);
        issue(32'h700, 32'h0000_7777, 1'b0, 1, 1'b1, 1'b0, a1);
        wait_drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
